// File: rtl/ip_arp_resolver_pkg.sv
// rtl/ip_arp_resolver_pkg.sv - shared types and constants for the ARP resolver
package ip_arp_resolver_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_QUERY,
        ST_WAIT,
        ST_RESPOND
    } arp_state_t;

    localparam logic [31:0] BCAST_IP  = 32'hFFFF_FFFF;
    localparam logic [47:0] BCAST_MAC = 48'hFFFF_FFFF_FFFF;

    typedef struct packed {
        logic        valid;
        logic [31:0] ip;
        logic [47:0] mac;
    } cache_entry_t;

    function automatic logic is_broadcast(input logic [31:0] dest, input logic [31:0] mask);
        return (dest == BCAST_IP) || ((dest | mask) == BCAST_IP);
    endfunction

    // 0.0.0.0 and the limited broadcast address are never cached.
    function automatic logic is_learnable(input logic [31:0] ip);
        return (ip != 32'd0) && (ip != BCAST_IP);
    endfunction

endpackage

// File: rtl/ip_arp_resolver_if.sv
// rtl/ip_arp_resolver_if.sv - request/response, query and learn handshakes of the ARP resolver
interface ip_arp_resolver_if;

    logic        arp_request_valid;
    logic        arp_request_ready;
    logic [31:0] arp_request_ip;
    logic        arp_response_valid;
    logic        arp_response_ready;
    logic        arp_response_error;
    logic [47:0] arp_response_mac;
    logic        query_valid;
    logic        query_ready;
    logic [31:0] query_ip;
    logic        cache_wr_valid;
    logic [31:0] cache_wr_ip;
    logic [47:0] cache_wr_mac;

    modport slave (
        input  arp_request_valid, arp_request_ip,
        output arp_request_ready,
        output arp_response_valid, arp_response_error, arp_response_mac,
        input  arp_response_ready,
        output query_valid, query_ip,
        input  query_ready,
        input  cache_wr_valid, cache_wr_ip, cache_wr_mac
    );

    modport master (
        output arp_request_valid, arp_request_ip,
        input  arp_request_ready,
        input  arp_response_valid, arp_response_error, arp_response_mac,
        output arp_response_ready,
        input  query_valid, query_ip,
        output query_ready,
        output cache_wr_valid, cache_wr_ip, cache_wr_mac
    );

endinterface

// File: rtl/ip_arp_resolver_cache_cam.sv
// rtl/ip_arp_resolver_cache_cam.sv - fully associative IP->MAC cache with round-robin replacement
module ip_arp_resolver_cache_cam
    import ip_arp_resolver_pkg::*;
#(
    parameter int CACHE_ENTRIES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic [31:0] lookup_ip,
    output logic        lookup_hit,
    output logic [47:0] lookup_mac,
    input  logic        wr_valid,
    input  logic [31:0] wr_ip,
    input  logic [47:0] wr_mac
);

    localparam int PW = $clog2(CACHE_ENTRIES);

    cache_entry_t  entries [CACHE_ENTRIES];
    logic [PW-1:0] ptr;
    logic          wr_accept;
    logic          wr_present;
    logic [PW-1:0] wr_idx;

    assign wr_accept = wr_valid && !clear && is_learnable(wr_ip);

    // A write landing on the looked-up IP is forwarded so the lookup sees the new MAC.
    always_comb begin
        wr_present = 1'b0;
        wr_idx     = '0;
        lookup_hit = 1'b0;
        lookup_mac = '0;
        for (int i = 0; i < CACHE_ENTRIES; i++) begin
            if (entries[i].valid && (entries[i].ip == wr_ip)) begin
                wr_present = 1'b1;
                wr_idx     = PW'(i);
            end
            if (entries[i].valid && (entries[i].ip == lookup_ip)) begin
                lookup_hit = 1'b1;
                lookup_mac = entries[i].mac;
            end
        end
        if (wr_accept && (wr_ip == lookup_ip)) begin
            lookup_hit = 1'b1;
            lookup_mac = wr_mac;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CACHE_ENTRIES; i++) begin
                entries[i] <= '0;
            end
            ptr <= '0;
        end else if (clear) begin
            for (int i = 0; i < CACHE_ENTRIES; i++) begin
                entries[i].valid <= 1'b0;
            end
        end else if (wr_accept) begin
            if (wr_present) begin
                entries[wr_idx].mac <= wr_mac;
            end else begin
                entries[ptr] <= '{valid: 1'b1, ip: wr_ip, mac: wr_mac};
                ptr          <= ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ip_arp_resolver.sv
// rtl/ip_arp_resolver.sv - next-hop ARP resolution with retrying who-has queries; ARP_RESOLVER_STATS_EN adds outcome counters
module ip_arp_resolver
    import ip_arp_resolver_pkg::*;
#(
    parameter int CACHE_ENTRIES  = 4,
    parameter int RETRY_COUNT    = 4,
    parameter int RETRY_INTERVAL = 1250000
) (
    input  logic                clk,
    input  logic                rst,
    ip_arp_resolver_if.slave    bus,
    input  logic                clear_cache,
    input  logic [31:0]         local_ip,
    input  logic [31:0]         gateway_ip,
    input  logic [31:0]         subnet_mask
`ifdef ARP_RESOLVER_STATS_EN
    ,
    output logic [31:0]         stat_hit,
    output logic [31:0]         stat_miss,
    output logic [31:0]         stat_timeout
`endif
);

    localparam int TW = $clog2(RETRY_INTERVAL + 1);
    localparam int RW = $clog2(RETRY_COUNT + 1);

    arp_state_t    state;
    logic [31:0]   next_hop;
    logic [TW-1:0] timer;
    logic [RW-1:0] sent;
    logic          hit;
    logic [47:0]   hit_mac;
    logic          accept;
    logic          bcast;
    logic [31:0]   hop_sel;
    logic          wr_hop;
    logic          give_up;

    assign accept  = bus.arp_request_valid && bus.arp_request_ready;
    assign bcast   = is_broadcast(bus.arp_request_ip, subnet_mask);
    assign hop_sel = ((bus.arp_request_ip & subnet_mask) != (local_ip & subnet_mask))
                   ? gateway_ip : bus.arp_request_ip;
    assign wr_hop  = bus.cache_wr_valid && is_learnable(bus.cache_wr_ip)
                   && (bus.cache_wr_ip == next_hop);
    assign give_up = (timer == '0) && (sent >= RW'(RETRY_COUNT));

    ip_arp_resolver_cache_cam #(.CACHE_ENTRIES(CACHE_ENTRIES)) u_cam (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear_cache),
        .lookup_ip  (next_hop),
        .lookup_hit (hit),
        .lookup_mac (hit_mac),
        .wr_valid   (bus.cache_wr_valid),
        .wr_ip      (bus.cache_wr_ip),
        .wr_mac     (bus.cache_wr_mac)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state                  <= ST_IDLE;
            bus.arp_request_ready  <= 1'b1;
            bus.arp_response_valid <= 1'b0;
            bus.arp_response_error <= 1'b0;
            bus.arp_response_mac   <= '0;
            bus.query_valid        <= 1'b0;
            bus.query_ip           <= '0;
            next_hop               <= '0;
            timer                  <= '0;
            sent                   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        bus.arp_request_ready <= 1'b0;
                        if (bcast) begin
                            next_hop               <= bus.arp_request_ip;
                            bus.arp_response_valid <= 1'b1;
                            bus.arp_response_error <= 1'b0;
                            bus.arp_response_mac   <= BCAST_MAC;
                            state                  <= ST_RESPOND;
                        end else begin
                            next_hop <= hop_sel;
                            state    <= ST_LOOKUP;
                        end
                    end
                end
                ST_LOOKUP: begin
                    sent <= '0;
                    if (hit) begin
                        bus.arp_response_valid <= 1'b1;
                        bus.arp_response_error <= 1'b0;
                        bus.arp_response_mac   <= hit_mac;
                        state                  <= ST_RESPOND;
                    end else begin
                        bus.query_valid <= 1'b1;
                        bus.query_ip    <= next_hop;
                        state           <= ST_QUERY;
                    end
                end
                ST_QUERY: begin
                    if (bus.query_ready) begin
                        bus.query_valid <= 1'b0;
                        timer           <= TW'(RETRY_INTERVAL);
                        sent            <= sent + 1'b1;
                        state           <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // A matching learn wins over an expiring timer in the same cycle.
                    if (wr_hop) begin
                        bus.arp_response_valid <= 1'b1;
                        bus.arp_response_error <= 1'b0;
                        bus.arp_response_mac   <= bus.cache_wr_mac;
                        state                  <= ST_RESPOND;
                    end else if (give_up) begin
                        bus.arp_response_valid <= 1'b1;
                        bus.arp_response_error <= 1'b1;
                        bus.arp_response_mac   <= '0;
                        state                  <= ST_RESPOND;
                    end else if (timer == '0) begin
                        bus.query_valid <= 1'b1;
                        state           <= ST_QUERY;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                ST_RESPOND: begin
                    if (bus.arp_response_ready) begin
                        bus.arp_response_valid <= 1'b0;
                        bus.arp_request_ready  <= 1'b1;
                        state                  <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef ARP_RESOLVER_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_hit     <= '0;
            stat_miss    <= '0;
            stat_timeout <= '0;
        end else begin
            if (((state == ST_IDLE) && accept && bcast) || ((state == ST_LOOKUP) && hit)) begin
                stat_hit <= stat_hit + 32'd1;
            end
            if ((state == ST_LOOKUP) && !hit) begin
                stat_miss <= stat_miss + 32'd1;
            end
            if ((state == ST_WAIT) && !wr_hop && give_up) begin
                stat_timeout <= stat_timeout + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ip_arp_resolver.sv
// tb/tb_ip_arp_resolver.sv - randomized self-checking bench for ip_arp_resolver against a cache reference model
module tb_ip_arp_resolver;

    localparam int CE = 4;
    localparam int RC = 2;
    localparam int RI = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear_cache = 1'b0;
    logic [31:0] local_ip    = 32'h0A00_0002;
    logic [31:0] gateway_ip  = 32'h0A00_0001;
    logic [31:0] subnet_mask = 32'hFFFF_FF00;

    int checks = 0;
    int errors = 0;

    logic        m_valid [CE];
    logic [31:0] m_ip    [CE];
    logic [47:0] m_mac   [CE];
    int          m_ptr;

    ip_arp_resolver_if bus();

`ifdef ARP_RESOLVER_STATS_EN
    logic [31:0] stat_hit, stat_miss, stat_timeout;
`endif

    ip_arp_resolver #(
        .CACHE_ENTRIES (CE),
        .RETRY_COUNT   (RC),
        .RETRY_INTERVAL(RI)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .clear_cache (clear_cache),
        .local_ip    (local_ip),
        .gateway_ip  (gateway_ip),
        .subnet_mask (subnet_mask)
`ifdef ARP_RESOLVER_STATS_EN
        ,
        .stat_hit    (stat_hit),
        .stat_miss   (stat_miss),
        .stat_timeout(stat_timeout)
`endif
    );

    always #5 clk = ~clk;

    function automatic void m_reset();
        for (int i = 0; i < CE; i++) m_valid[i] = 1'b0;
        m_ptr = 0;
    endfunction

    function automatic void m_clear();
        for (int i = 0; i < CE; i++) m_valid[i] = 1'b0;
    endfunction

    function automatic void m_write(input logic [31:0] ip, input logic [47:0] mac);
        if (ip == 32'd0 || ip == 32'hFFFF_FFFF) return;
        for (int i = 0; i < CE; i++) begin
            if (m_valid[i] && m_ip[i] == ip) begin
                m_mac[i] = mac;
                return;
            end
        end
        m_valid[m_ptr] = 1'b1;
        m_ip[m_ptr]    = ip;
        m_mac[m_ptr]   = mac;
        m_ptr          = (m_ptr + 1) % CE;
    endfunction

    function automatic bit m_lookup(input logic [31:0] ip, output logic [47:0] mac);
        mac = '0;
        for (int i = 0; i < CE; i++) begin
            if (m_valid[i] && m_ip[i] == ip) begin
                mac = m_mac[i];
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    function automatic logic [47:0] rand_mac();
        return {16'($urandom), 32'($urandom)};
    endfunction

    task automatic cache_write(input logic [31:0] ip, input logic [47:0] mac, input bit with_clear);
        bus.cache_wr_valid = 1'b1;
        bus.cache_wr_ip    = ip;
        bus.cache_wr_mac   = mac;
        clear_cache        = with_clear;
        @(posedge clk); #1;
        bus.cache_wr_valid = 1'b0;
        clear_cache        = 1'b0;
        if (with_clear) m_clear();
        else m_write(ip, mac);
    endtask

    // inject: cycle after acceptance at which a learn of inj_ip is driven (-1 = none)
    task automatic do_request(input string name, input logic [31:0] dest, input int inject,
                              input logic [31:0] inj_ip, input logic [47:0] inj_mac, input int hold);
        logic [31:0] hop;
        logic [47:0] exp_mac, mmac, mac0;
        bit          exp_err, err0, got, bad_qip, unstable;
        int          exp_lat, exp_q, lat, nq;
        hop = ((dest & subnet_mask) != (local_ip & subnet_mask)) ? gateway_ip : dest;
        exp_err = 1'b0;
        exp_lat = 2;
        exp_q   = 0;
        if (dest == 32'hFFFF_FFFF || (dest | subnet_mask) == 32'hFFFF_FFFF) begin
            exp_mac = 48'hFFFF_FFFF_FFFF;
            exp_lat = 1;
        end else if (inject == 0 && inj_ip == hop) begin
            exp_mac = inj_mac;
        end else if (m_lookup(hop, mmac)) begin
            exp_mac = mmac;
        end else if (inject > 0 && inj_ip == hop) begin
            exp_mac = inj_mac;
            exp_lat = -1;
            exp_q   = 1;
        end else begin
            exp_mac = '0;
            exp_err = 1'b1;
            exp_lat = -1;
            exp_q   = RC;
        end
        checks++;
        if (bus.arp_request_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_before: got %b expected 1", name, bus.arp_request_ready);
        end
        bus.arp_request_valid = 1'b1;
        bus.arp_request_ip    = dest;
        @(posedge clk); #1;
        bus.arp_request_valid = 1'b0;
        lat = 1; nq = 0; got = 1'b0; bad_qip = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (bus.query_valid) begin
                nq++;
                if (bus.query_ip !== hop) bad_qip = 1'b1;
            end
            if (bus.arp_response_valid) begin
                got = 1'b1;
                break;
            end
            if (c == inject) begin
                bus.cache_wr_valid = 1'b1;
                bus.cache_wr_ip    = inj_ip;
                bus.cache_wr_mac   = inj_mac;
            end
            @(posedge clk); #1;
            if (c == inject) begin
                bus.cache_wr_valid = 1'b0;
                m_write(inj_ip, inj_mac);
            end
            lat++;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s response_timeout: got no response expected one within 400 cycles", name);
        end
        if (exp_lat > 0) begin
            checks++;
            if (lat != exp_lat) begin
                errors++;
                $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
            end
        end
        checks++;
        if (bus.arp_response_mac !== exp_mac) begin
            errors++;
            $display("FAIL %s mac: got %h expected %h", name, bus.arp_response_mac, exp_mac);
        end
        checks++;
        if (bus.arp_response_error !== exp_err) begin
            errors++;
            $display("FAIL %s error: got %b expected %b", name, bus.arp_response_error, exp_err);
        end
        checks++;
        if (nq != exp_q || bad_qip) begin
            errors++;
            $display("FAIL %s queries: got %0d (bad ip %b) expected %0d", name, nq, bad_qip, exp_q);
        end
        mac0 = bus.arp_response_mac;
        err0 = bus.arp_response_error;
        unstable = 1'b0;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            if (bus.arp_response_valid !== 1'b1 || bus.arp_response_mac !== mac0 ||
                bus.arp_response_error !== err0) unstable = 1'b1;
        end
        if (hold > 0) begin
            checks++;
            if (unstable) begin
                errors++;
                $display("FAIL %s hold_stable: got changing outputs expected stable for %0d cycles", name, hold);
            end
        end
        bus.arp_response_ready = 1'b1;
        @(posedge clk); #1;
        bus.arp_response_ready = 1'b0;
        checks++;
        if (bus.arp_response_valid !== 1'b0 || bus.arp_request_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s after_consume: got valid=%b ready=%b expected valid=0 ready=1",
                     name, bus.arp_response_valid, bus.arp_request_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.arp_request_ready !== 1'b1 || bus.arp_response_valid !== 1'b0 ||
            bus.query_valid !== 1'b0 || bus.arp_response_error !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got ready=%b rvalid=%b qvalid=%b err=%b expected 1 0 0 0",
                     bus.arp_request_ready, bus.arp_response_valid, bus.query_valid, bus.arp_response_error);
        end
        checks++;
        if (bus.arp_response_mac !== 48'd0 || bus.query_ip !== 32'd0) begin
            errors++;
            $display("FAIL reset_data: got mac=%h qip=%h expected 0 0", bus.arp_response_mac, bus.query_ip);
        end
        rst = 1'b0;
        m_reset();
        @(posedge clk); #1;
    endtask

    task automatic test_hit();
        cache_write(32'h0A00_0005, 48'h0200_0000_0005, 1'b0);
        do_request("hit_basic", 32'h0A00_0005, -1, 32'd0, 48'd0, 0);
    endtask

    task automatic test_broadcast();
        do_request("bcast_subnet", 32'h0A00_00FF, -1, 32'd0, 48'd0, 0);
        do_request("bcast_all", 32'hFFFF_FFFF, -1, 32'd0, 48'd0, 0);
    endtask

    task automatic test_gateway();
        cache_write(gateway_ip, rand_mac(), 1'b0);
        do_request("gateway", 32'h0808_0808, -1, 32'd0, 48'd0, 0);
    endtask

    task automatic test_timeout();
        cache_write(32'd0, 48'd0, 1'b1);
        do_request("timeout", 32'h0A00_0009, -1, 32'd0, 48'd0, 0);
        do_request("wait_learn", 32'h0A00_0009 + 32'd0, 5, 32'h0A00_0009, rand_mac(), 0);
        cache_write(32'd0, 48'd0, 1'b1);
        do_request("lookup_forward", 32'h0A00_0021, 0, 32'h0A00_0021, rand_mac(), 0);
    endtask

    task automatic test_replace();
        cache_write(32'd0, 48'd0, 1'b1);
        for (int i = 0; i < 5; i++) cache_write(32'h0A00_0040 + 32'(i), rand_mac(), 1'b0);
        for (int i = 0; i < 5; i++) do_request("replace", 32'h0A00_0040 + 32'(i), -1, 32'd0, 48'd0, 0);
        cache_write(32'h0A00_0050, rand_mac(), 1'b1);
        do_request("clear_wr_new", 32'h0A00_0050, -1, 32'd0, 48'd0, 0);
        do_request("clear_wr_old", 32'h0A00_0044, -1, 32'd0, 48'd0, 0);
    endtask

    task automatic test_random();
        logic [31:0] dest;
        for (int n = 0; n < 12; n++) begin
            if ($urandom_range(0, 9) < 6)
                cache_write(32'h0A00_0010 + 32'($urandom_range(0, 5)), rand_mac(), 1'b0);
            if ($urandom_range(0, 4) == 0) dest = {8'd172, 8'd16, 16'($urandom)};
            else dest = 32'h0A00_0010 + 32'($urandom_range(0, 5));
            do_request("random", dest, -1, 32'd0, 48'd0, 0);
        end
    endtask

    task automatic test_hold();
        cache_write(32'h0A00_0077, rand_mac(), 1'b0);
        do_request("hold_hit", 32'h0A00_0077, -1, 32'd0, 48'd0, 10);
        do_request("hold_bcast", 32'h0A00_00FF, -1, 32'd0, 48'd0, 10);
    endtask

    task automatic test_rst_wait();
        bit seen_q, late;
        cache_write(32'd0, 48'd0, 1'b1);
        bus.arp_request_valid = 1'b1;
        bus.arp_request_ip    = 32'h0A00_0066;
        @(posedge clk); #1;
        bus.arp_request_valid = 1'b0;
        seen_q = 1'b0;
        for (int c = 0; c < 10 && !seen_q; c++) begin
            if (bus.query_valid) seen_q = 1'b1;
            @(posedge clk); #1;
        end
        checks++;
        if (!seen_q) begin
            errors++;
            $display("FAIL rst_wait_query: got no query expected one for a miss");
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_reset();
        checks++;
        if (bus.arp_request_ready !== 1'b1 || bus.arp_response_valid !== 1'b0 || bus.query_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_wait_idle: got ready=%b rvalid=%b qvalid=%b expected 1 0 0",
                     bus.arp_request_ready, bus.arp_response_valid, bus.query_valid);
        end
        late = 1'b0;
        for (int c = 0; c < 60; c++) begin
            if (bus.arp_response_valid || bus.query_valid) late = 1'b1;
            @(posedge clk); #1;
        end
        checks++;
        if (late) begin
            errors++;
            $display("FAIL rst_wait_dropped: got activity after reset expected none");
        end
        cache_write(32'h0A00_0066, rand_mac(), 1'b0);
        do_request("after_rst", 32'h0A00_0066, -1, 32'd0, 48'd0, 0);
    endtask

    initial begin
        bus.arp_request_valid  = 1'b0;
        bus.arp_request_ip     = '0;
        bus.arp_response_ready = 1'b0;
        bus.query_ready        = 1'b1;
        bus.cache_wr_valid     = 1'b0;
        bus.cache_wr_ip        = '0;
        bus.cache_wr_mac       = '0;
        m_reset();
        test_reset();
        test_hit();
        test_broadcast();
        test_gateway();
        test_timeout();
        test_replace();
        test_random();
        test_hold();
        test_rst_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no end of test expected finish before 100000 cycles");
        $fatal(1, "watchdog expired");
    end

endmodule
